// File: rtl/i2c_seq_pkg.sv
// i2c_seq_pkg: shared state encoding and sizing for the I2C slave bit sequencer.
package i2c_seq_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SHIFT    = 3'd1,
        BYTE_END = 3'd2,
        ACK_LOW  = 3'd3,
        ACK_HIGH = 3'd4
    } seq_state_t;

    localparam int BIT_CNT_W          = 4;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/i2c_bit_sequencer_watchdog.sv
// seq_watchdog: idle-cycle counter that pulses tc after CYCLES uncleared clocks.
module seq_watchdog
    import i2c_seq_pkg::*;
#(
    parameter int CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clr,
    output logic tc
);

    localparam int CW = (CYCLES > 2) ? $clog2(CYCLES) : 1;

    logic [CW-1:0] cnt;

    assign tc = !clr && (cnt == CW'(CYCLES - 1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            cnt <= '0;
        else
            cnt <= (clr || tc) ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/i2c_bit_sequencer.sv
// i2c_bit_sequencer: slave-side SCL bit/byte sequencer with ACK-slot handshakes.
// Optional SCL watchdog abort enabled by defining SEQ_TIMEOUT_EN.
module i2c_bit_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int BITS_PER_BYTE  = 8,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 rising_edge_found,
    input  logic                 falling_edge_found,
    input  logic                 start_found,
    input  logic                 stop_found,
    output logic                 shift_strobe,
    output logic                 byte_received,
    output logic                 ack_prep,
    output logic                 check_ack,
    output logic                 ack_done,
    output logic [BIT_CNT_W-1:0] bit_count,
    output logic                 busy,
    output logic                 timeout
);

    seq_state_t           state;
    logic                 tc;
    logic [BIT_CNT_W-1:0] next_cnt;

    assign busy     = (state != IDLE);
    assign next_cnt = bit_count + 1'b1;

`ifdef SEQ_TIMEOUT_EN
    seq_watchdog #(.CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (rising_edge_found || falling_edge_found || start_found || stop_found || !busy),
        .tc    (tc)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            timeout <= 1'b0;
        else
            timeout <= tc;
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign tc                 = 1'b0;
    assign timeout            = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= IDLE;
            bit_count     <= '0;
            shift_strobe  <= 1'b0;
            byte_received <= 1'b0;
            ack_prep      <= 1'b0;
            check_ack     <= 1'b0;
            ack_done      <= 1'b0;
        end else begin
            shift_strobe  <= 1'b0;
            byte_received <= 1'b0;
            check_ack     <= 1'b0;
            ack_done      <= 1'b0;
            if (stop_found || tc) begin
                state     <= IDLE;
                bit_count <= '0;
                ack_prep  <= 1'b0;
            end else if (start_found) begin
                state     <= SHIFT;
                bit_count <= '0;
                ack_prep  <= 1'b0;
            end else if (rising_edge_found ^ falling_edge_found) begin
                // first falling edge after START is just the clock-low phase
                case (state)
                    SHIFT: if (rising_edge_found) begin
                        shift_strobe <= 1'b1;
                        bit_count    <= next_cnt;
                        if (next_cnt == BIT_CNT_W'(BITS_PER_BYTE))
                            state <= BYTE_END;
                    end
                    BYTE_END: if (falling_edge_found) begin
                        byte_received <= 1'b1;
                        ack_prep      <= 1'b1;
                        state         <= ACK_LOW;
                    end
                    ACK_LOW: if (rising_edge_found) begin
                        check_ack <= 1'b1;
                        state     <= ACK_HIGH;
                    end
                    ACK_HIGH: if (falling_edge_found) begin
                        ack_done  <= 1'b1;
                        ack_prep  <= 1'b0;
                        bit_count <= '0;
                        state     <= SHIFT;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_bit_sequencer.sv
// tb_i2c_bit_sequencer: vector-table and scoreboard bench for the I2C bit sequencer.
// Timeout expectations follow SEQ_TIMEOUT_EN when it is defined for the build.
module tb_i2c_bit_sequencer;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       rise = 1'b0, fall = 1'b0, start = 1'b0, stop = 1'b0;
    logic       shift_strobe, byte_received, ack_prep, check_ack, ack_done, busy, timeout;
    logic [3:0] bit_count;

    int total = 0;
    int bad   = 0;

    // output vector order: {shift_strobe, byte_received, ack_prep, check_ack, ack_done, busy, timeout}
    localparam logic [6:0] IDL = 7'b0000000;
    localparam logic [6:0] B   = 7'b0000010;
    localparam logic [6:0] STB = 7'b1000010;
    localparam logic [6:0] BYT = 7'b0110010;
    localparam logic [6:0] PRP = 7'b0010010;
    localparam logic [6:0] CHK = 7'b0011010;
    localparam logic [6:0] DON = 7'b0000110;
    localparam logic [6:0] TMO = 7'b0000001;

    typedef struct {
        int         t;
        logic       r, f, s, p;
        logic [6:0] o;
        logic [3:0] c;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    i2c_bit_sequencer #(.BITS_PER_BYTE(8), .TIMEOUT_CYCLES(16)) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .rising_edge_found  (rise),
        .falling_edge_found (fall),
        .start_found        (start),
        .stop_found         (stop),
        .shift_strobe       (shift_strobe),
        .byte_received      (byte_received),
        .ack_prep           (ack_prep),
        .check_ack          (check_ack),
        .ack_done           (ack_done),
        .bit_count          (bit_count),
        .busy               (busy),
        .timeout            (timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] outs();
        return {shift_strobe, byte_received, ack_prep, check_ack, ack_done, busy, timeout};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic add(input int t, input logic r, f, s, p, input logic [6:0] o, input logic [3:0] c);
        vec_t v;
        v.t = t; v.r = r; v.f = f; v.s = s; v.p = p; v.o = o; v.c = c;
        tbl.push_back(v);
    endtask

    task automatic add_bits(input int t, input int from, input int to);
        for (int k = from; k <= to; k++) begin
            add(t, 1, 0, 0, 0, STB, 4'(k));
            add(t, 0, 1, 0, 0, (k == 8) ? BYT : B, 4'(k));
        end
    endtask

    task automatic add_ack(input int t);
        add(t, 1, 0, 0, 0, CHK, 8);
        add(t, 0, 1, 0, 0, DON, 0);
    endtask

    task automatic run();
        for (int i = 0; i < tbl.size(); i++) begin
            vec_t v, e;
            v = tbl[i];
            rise = v.r; fall = v.f; start = v.s; stop = v.p;
            sb.push_back(v);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk($sformatf("t%0d step%0d outputs", e.t, i), outs(), e.o);
            chk($sformatf("t%0d step%0d bit_count", e.t, i), bit_count, e.c);
        end
        tbl.delete();
        rise = 0; fall = 0; start = 0; stop = 0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs", outs(), IDL);
        chk("reset bit_count", bit_count, 0);
        n_rst = 1'b1;
        // single byte with ignored edges: IDLE edge, first fall, illegal pair, rise in BYTE_END
        add(1, 1, 0, 0, 0, IDL, 0);
        add(1, 0, 0, 1, 0, B, 0);
        add(1, 0, 1, 0, 0, B, 0);
        add_bits(1, 1, 3);
        add(1, 1, 1, 0, 0, B, 3);
        add(1, 0, 0, 0, 0, B, 3);
        add_bits(1, 4, 7);
        add(1, 1, 0, 0, 0, STB, 8);
        add(1, 1, 0, 0, 0, B, 8);
        add(1, 0, 1, 0, 0, BYT, 8);
        add(1, 0, 0, 0, 0, PRP, 8);
        add_ack(1);
        add(1, 0, 0, 0, 1, IDL, 0);
        // two back-to-back bytes then STOP, edge in IDLE ignored
        add(2, 0, 0, 1, 0, B, 0);
        add_bits(2, 1, 8);
        add_ack(2);
        add_bits(2, 1, 8);
        add_ack(2);
        add(2, 0, 0, 0, 1, IDL, 0);
        add(2, 1, 0, 0, 0, IDL, 0);
        add(2, 0, 1, 0, 0, IDL, 0);
        // repeated START mid-byte with a same-cycle rise that must be dropped
        add(3, 0, 0, 1, 0, B, 0);
        add_bits(3, 1, 3);
        add(3, 1, 0, 1, 0, B, 0);
        add_bits(3, 1, 8);
        add_ack(3);
        add(3, 0, 0, 0, 1, IDL, 0);
        // STOP in ACK_LOW, repeated START in ACK_LOW and ACK_HIGH
        add(4, 0, 0, 1, 0, B, 0);
        add_bits(4, 1, 8);
        add(4, 1, 0, 0, 1, IDL, 0);
        add(4, 1, 0, 0, 0, IDL, 0);
        add(4, 0, 0, 1, 0, B, 0);
        add_bits(4, 1, 8);
        add(4, 0, 0, 1, 0, B, 0);
        add_bits(4, 1, 8);
        add(4, 1, 0, 0, 0, CHK, 8);
        add(4, 0, 1, 1, 0, B, 0);
        add(4, 0, 0, 0, 1, IDL, 0);
        // SCL stalls after two bits
        add(6, 0, 0, 1, 0, B, 0);
        add_bits(6, 1, 2);
`ifdef SEQ_TIMEOUT_EN
        for (int j = 1; j <= 15; j++) add(6, 0, 0, 0, 0, B, 2);
        add(6, 0, 0, 0, 0, TMO, 0);
        add(6, 0, 0, 0, 0, IDL, 0);
        add(6, 1, 0, 0, 0, IDL, 0);
`else
        for (int j = 1; j <= 24; j++) add(6, 0, 0, 0, 0, B, 2);
        add(6, 0, 0, 0, 1, IDL, 0);
`endif
        run();
        // async reset mid-frame
        add(5, 0, 0, 1, 0, B, 0);
        add_bits(5, 1, 5);
        run();
        n_rst = 1'b0;
        #2;
        chk("t5 async reset outputs", outs(), IDL);
        chk("t5 async reset bit_count", bit_count, 0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        add(5, 1, 0, 0, 0, IDL, 0);
        add(5, 0, 1, 0, 0, IDL, 0);
        add(5, 1, 0, 0, 0, IDL, 0);
        add(5, 0, 0, 1, 0, B, 0);
        add(5, 1, 0, 0, 0, STB, 1);
        run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
